// File: rtl/vram_pkg.sv
// Shared definitions for the video RAM loader: default widths and FSM state encoding.
package vram_pkg;

  localparam int RAM_AW_DEF = 11;
  localparam int ROM_AW_DEF = 12;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/vram_wr_stage.sv
// One-cycle write pipeline: captures an issued RAM address and data source so
// the write lines up with the ROM byte that arrives one cycle after rom_ce.
module vram_wr_stage
  import vram_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic [RAM_AW-1:0] issue_ad,
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_data
);

  logic              we_reg;
  logic [RAM_AW-1:0] ad_reg;
  logic              fill_reg;
  logic [DATA_W-1:0] fval_reg;

  // Pipeline register; address and data select drop back to 0 when nothing is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_reg   <= 1'b0;
      ad_reg   <= '0;
      fill_reg <= 1'b0;
      fval_reg <= '0;
    end else begin
      we_reg <= issue;
      if (issue) begin
        ad_reg   <= issue_ad;
        fill_reg <= fill_mode;
        fval_reg <= fill_value;
      end else begin
        ad_reg   <= '0;
        fill_reg <= 1'b0;
        fval_reg <= '0;
      end
    end
  end

  assign ram_we   = we_reg;
  assign ram_ad   = ad_reg;
  // ROM data is only valid during the write cycle, so the select is combinational.
  assign ram_data = we_reg ? (fill_reg ? fval_reg : rom_data) : '0;

endmodule

// File: rtl/vram_loader.sv
// Video RAM loader: copies every even ROM byte (2:1 decimation) into video RAM,
// or fills the RAM with a constant. Supports abort and reports busy/done.
module vram_loader
  import vram_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEF,
  parameter int ROM_AW = ROM_AW_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_value,
  output logic              rom_ce,
  output logic [ROM_AW-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_data,
  output logic              busy,
  output logic              done
);

  localparam logic [RAM_AW-1:0] CNT_MAX = '1;

  state_t            state_reg, state_next;
  logic [RAM_AW-1:0] cnt_reg, cnt_next;
  logic              fill_mode_reg, fill_mode_next;
  logic [DATA_W-1:0] fill_value_reg, fill_value_next;
  logic              done_reg, done_next;
  logic              issue;

  // State, source counter, latched mode/value and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      fill_mode_reg  <= 1'b0;
      fill_value_reg <= '0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      fill_mode_reg  <= fill_mode_next;
      fill_value_reg <= fill_value_next;
      done_reg       <= done_next;
    end
  end

  // Next-state logic; the counter saturates at CNT_MAX and is cleared on leaving a load.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    fill_mode_next  = fill_mode_reg;
    fill_value_next = fill_value_reg;
    done_next       = 1'b0;
    issue           = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (start && !abort) begin
          state_next      = ISSUE;
          fill_mode_next  = fill_mode;
          fill_value_next = fill_value;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          issue = 1'b1;
          if (cnt_reg == CNT_MAX) begin
            state_next = DRAIN;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        state_next = IDLE;
        cnt_next   = '0;
        done_next  = !abort;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;
  assign rom_ce = (state_reg == ISSUE) && !fill_mode_reg;
  assign rom_ad = (state_reg == ISSUE) ? {cnt_reg, 1'b0} : '0;

  vram_wr_stage #(
    .RAM_AW(RAM_AW),
    .DATA_W(DATA_W)
  ) u_wr_stage (
    .clk       (clk),
    .reset     (reset),
    .issue     (issue),
    .issue_ad  (cnt_reg),
    .fill_mode (fill_mode_reg),
    .fill_value(fill_value_reg),
    .rom_data  (rom_data),
    .ram_we    (ram_we),
    .ram_ad    (ram_ad),
    .ram_data  (ram_data)
  );

endmodule

// File: tb/tb_vram_loader.sv
// Testbench for vram_loader: table-driven load scenarios plus hand-written idle/reset sequences.
module tb_vram_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        fill_mode;
  logic [7:0]  fill_value;
  logic        rom_ce;
  logic [11:0] rom_ad;
  logic [7:0]  rom_data = 8'h00;
  logic        ram_we;
  logic [10:0] ram_ad;
  logic [7:0]  ram_data;
  logic        busy;
  logic        done;

  vram_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .fill_mode (fill_mode),
    .fill_value(fill_value),
    .rom_ce    (rom_ce),
    .rom_ad    (rom_ad),
    .rom_data  (rom_data),
    .ram_we    (ram_we),
    .ram_ad    (ram_ad),
    .ram_data  (ram_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // ROM model: byte[a] = a[7:0], one cycle after rom_ce; junk otherwise.
  always @(posedge clk) rom_data <= rom_ce ? rom_ad[7:0] : 8'hEE;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Monitor state
  bit         mon_en = 0;
  int         t0, r_mon, evt_at;
  logic       fill_s;
  logic [7:0] fv_s;
  logic [7:0] ed;
  int n_we, n_done, n_busy, n_ce, odd_ad, ad_err, data_err, exp_ad;
  int first_we, last_we, first_busy, done_r, last_ad, after_nz;

  task automatic clear_stats();
    n_we = 0; n_done = 0; n_busy = 0; n_ce = 0; odd_ad = 0; ad_err = 0; data_err = 0;
    exp_ad = 0; first_we = -1; last_we = -1; first_busy = -1; done_r = -1; last_ad = -1;
    after_nz = 1;
  endtask

  // Sample outputs on the falling edge and accumulate scenario statistics.
  always @(negedge clk) begin
    if (mon_en) begin
      r_mon = cyc - t0;
      if (busy) begin
        n_busy++;
        if (first_busy < 0) first_busy = r_mon;
      end
      if (rom_ce) n_ce++;
      if (rom_ad[0]) odd_ad++;
      if (ram_we) begin
        n_we++;
        if (first_we < 0) first_we = r_mon;
        last_we = r_mon;
        last_ad = int'(ram_ad);
        if (int'(ram_ad) != exp_ad) ad_err++;
        ed = fill_s ? fv_s : 8'((2 * int'(ram_ad)) % 256);
        if (ram_data !== ed) data_err++;
        exp_ad++;
      end
      if (done) begin
        n_done++;
        done_r = r_mon;
      end
      if (evt_at > 0 && r_mon == evt_at + 1)
        after_nz = int'(busy | done | rom_ce | ram_we | (rom_ad != 0) | (ram_ad != 0) | (ram_data != 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       fill;
    logic [7:0] fval;
    int         abort_at;
    int         dup_at;
    int         reset_at;
    int         exp_we;
    int         exp_done;
    int         exp_busy;
    int         exp_ce;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // fill, fval, abort_at, dup_at, reset_at, writes, done, busy cycles, rom_ce cycles
    vecs[0] = '{1'b0, 8'h00,    0,   0,    0, 2048, 1, 2049, 2048}; // plain copy
    vecs[1] = '{1'b1, 8'hA5,    0,   0,    0, 2048, 1, 2049,    0}; // fill A5
    vecs[2] = '{1'b0, 8'h00,  100,   0,    0,   99, 0,  100,  100}; // abort at busy 100
    vecs[3] = '{1'b0, 8'h00,    0, 500,    0, 2048, 1, 2049, 2048}; // restart after abort, start while busy
    vecs[4] = '{1'b0, 8'h00,    0,   0, 1000,  999, 0, 1000, 1000}; // reset at busy 1000
    vecs[5] = '{1'b0, 8'h00,    0,   0,    0, 2048, 1, 2049, 2048}; // full load after reset
    vecs[6] = '{1'b1, 8'h3C, 2049,   0,    0, 2048, 0, 2049,    0}; // abort in DRAIN
    vecs[7] = '{1'b0, 8'h00,    1,   0,    0,    0, 0,    1,    1}; // abort on first busy cycle

    reset = 1'b1; start = 1'b1; abort = 1'b0; fill_mode = 1'b0; fill_value = 8'h00;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_outs", int'(rom_ce | ram_we | (rom_ad != 0) | (ram_ad != 0) | (ram_data != 0)), 0);
    reset = 1'b0; start = 1'b0;
    repeat (3) tick();
    chk("rst_start_ignored", int'(busy), 0);

    // start and abort together in IDLE: no activity
    clear_stats(); evt_at = 0; fill_s = 1'b0; fv_s = 8'h00; t0 = cyc; mon_en = 1;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (20) tick();
    mon_en = 0;
    chk("idle_collide_busy", n_busy, 0);
    chk("idle_collide_we", n_we + n_ce + n_done, 0);
    $display("seq start+abort idle: busy=%0d we=%0d ce=%0d done=%0d", n_busy, n_we, n_ce, n_done);

    for (int i = 0; i < 8; i++) begin
      clear_stats();
      fill_s = vecs[i].fill; fv_s = vecs[i].fval;
      evt_at = (vecs[i].abort_at > 0) ? vecs[i].abort_at : vecs[i].reset_at;
      fill_mode = vecs[i].fill; fill_value = vecs[i].fval;
      t0 = cyc; mon_en = 1;
      start = 1'b1;
      for (int r = 1; r <= 2060; r++) begin
        tick();
        start = (r == vecs[i].dup_at) ? 1'b1 : 1'b0;
        abort = (r == vecs[i].abort_at) ? 1'b1 : 1'b0;
        reset = (r == vecs[i].reset_at) ? 1'b1 : 1'b0;
        fill_mode = 1'b0; fill_value = 8'hFF;
      end
      start = 1'b0; abort = 1'b0; reset = 1'b0;
      tick();
      mon_en = 0;
      chk($sformatf("v%0d_writes", i), n_we, vecs[i].exp_we);
      chk($sformatf("v%0d_done", i), n_done, vecs[i].exp_done);
      chk($sformatf("v%0d_busy", i), n_busy, vecs[i].exp_busy);
      chk($sformatf("v%0d_rom_ce", i), n_ce, vecs[i].exp_ce);
      chk($sformatf("v%0d_ad_order", i), ad_err, 0);
      chk($sformatf("v%0d_data", i), data_err, 0);
      chk($sformatf("v%0d_odd_rom_ad", i), odd_ad, 0);
      chk($sformatf("v%0d_first_busy", i), first_busy, 1);
      if (evt_at > 0) chk($sformatf("v%0d_after_event_zero", i), after_nz, 0);
      if (vecs[i].exp_done == 1) begin
        chk($sformatf("v%0d_first_we", i), first_we, 2);
        chk($sformatf("v%0d_last_we", i), last_we, 2049);
        chk($sformatf("v%0d_done_cycle", i), done_r, 2050);
        chk($sformatf("v%0d_last_ad", i), last_ad, 2047);
      end
      $display("vec %0d: fill=%0d writes=%0d done=%0d busy=%0d ce=%0d last_ad=%0d done_at=%0d",
               i, vecs[i].fill, n_we, n_done, n_busy, n_ce, last_ad, done_r);
      repeat (3) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_loader.md
VRAM_LOADER -- requirements
Module: vram_loader

Interface
REQ-001 Parameter RAM_AW, default 11: video RAM address width; 2**RAM_AW entries.
REQ-002 Parameter ROM_AW, default 12: image ROM address width; SHALL equal RAM_AW+1.
REQ-003 Parameter DATA_W, default 8: pixel byte width.
REQ-004 Port clk  input  1: single clock, rising edge; all logic in this domain.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port start  input  1: one-cycle request to begin a load.
REQ-007 Port abort  input  1: cancel an in-progress load.
REQ-008 Port fill_mode  input  1: sampled at start; 0 = copy ROM, 1 = write constant.
REQ-009 Port fill_value  input  DATA_W: constant written in fill mode; sampled at start.
REQ-010 Port rom_ce  output  1: ROM read enable.
REQ-011 Port rom_ad  output  ROM_AW: ROM address.
REQ-012 Port rom_data  input  DATA_W: ROM output, valid exactly 1 cycle after rom_ce.
REQ-013 Port ram_we  output  1: video RAM write enable.
REQ-014 Port ram_ad  output  RAM_AW: video RAM write address.
REQ-015 Port ram_data  output  DATA_W: video RAM write data.
REQ-016 Port busy  output  1: load in progress.
REQ-017 Port done  output  1: one-cycle pulse on successful completion.

Function
REQ-018 The block SHALL implement states IDLE, ISSUE, DRAIN.
REQ-019 IDLE: start=1 and abort=0 -> ISSUE next cycle; latch fill_mode and fill_value; source counter cleared to 0.
REQ-020 ISSUE: each cycle, rom_ce=1 (copy mode only; 0 in fill mode), rom_ad = 2*n for source index n; n increments by 1.
REQ-021 ROM addressing SHALL decimate 2:1 (even bytes only): rom_ad = {n, 1'b0}; odd ROM addresses are never read.
REQ-022 Write SHALL follow issue by exactly 1 cycle: ram_we=1, ram_ad=n, ram_data=rom_data (copy) or latched fill_value (fill).
REQ-023 ISSUE -> DRAIN after issuing n = 2**RAM_AW-1; DRAIN performs the final write, then -> IDLE.
REQ-024 done SHALL pulse for exactly one cycle, the cycle after the final write (ram_ad = 2**RAM_AW-1).
REQ-025 busy SHALL be 1 in ISSUE and DRAIN, 0 in IDLE; a full load SHALL take 2**RAM_AW+1 busy cycles (2049 by default).
REQ-026 start while busy SHALL be ignored; no restart, no counter change.
REQ-027 abort while busy SHALL return to IDLE next cycle; any pending write SHALL be dropped (ram_we=0 that cycle); done SHALL NOT pulse.
REQ-028 start and abort asserted together in IDLE: abort wins; block stays IDLE.
REQ-029 Counters SHALL NOT wrap past 2**RAM_AW-1; no write to address 0 after the last write.
REQ-030 In IDLE: rom_ce=0, ram_we=0; rom_ad, ram_ad, ram_data SHALL be held at 0.

Reset
REQ-031 reset=1 SHALL force IDLE on the next edge, regardless of state; busy=0, done=0, rom_ce=0, ram_we=0, all addresses/data 0.
REQ-032 Reset mid-load SHALL drop any pending write and SHALL NOT pulse done; start in the same cycle as reset SHALL be ignored.

Structure
REQ-033 The state encoding and the defaults for RAM_AW/ROM_AW/DATA_W SHALL live in a shared package, vram_pkg.
REQ-034 The 1-cycle write-pipeline register (we, ad, data select) SHALL be a separate sub-module, vram_wr_stage; FSM and counters stay in vram_loader.

Verification
REQ-035 Copy: ROM model byte[a]=a[7:0]; start at cycle 0 -> ram_we at cycles 2..2049; ram_ad=k carries data (2k)[7:0]; done at cycle 2050; busy cycles 1..2049.
REQ-036 Fill: fill_mode=1, fill_value=8'hA5, start -> 2048 writes of 8'hA5, rom_ce never 1, done once.
REQ-037 Abort: abort on the 100th busy cycle -> next cycle busy=0, ram_we=0; no done; a new start restarts at ram_ad=0.
REQ-038 Collisions: start pulsed during busy -> ignored, single done; start+abort in IDLE -> no activity.
REQ-039 Reset: reset at busy cycle 1000 -> all outputs 0 next cycle; no done; a later start completes normally with 2048 writes.
REQ-040 Boundary: last write ram_ad=2047 from rom_ad=4094; no write to address 0 follows; rom_ad never odd.
